// File: rtl/ip4_pkg.sv
// Shared constants, state encoding and byte-order helper for the IPv4 header inserter.
package ip4_pkg;

   localparam int SA_IP4_SIZE   = 32;
   localparam int DA_IP4_SIZE   = 32;
   localparam int IP4_HDR_BYTES = 20;

   localparam logic [7:0]  IP4_VER_IHL    = 8'h45;
   localparam logic [15:0] IP4_FLAGS_FRAG = 16'h4000;

   typedef enum logic [2:0] {
      IDLE,
      CSUM,
      HDR0,
      HDR0B,
      HDR1,
      DATA,
      TAIL
   } ip4_state_e;

   // Header fields are assembled in network order (first byte in the MSBs);
   // the stream carries byte 0 in tdata[7:0], so the beat is byte-reversed.
   function automatic logic [63:0] be_to_lanes(input logic [63:0] be);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = be[8*(7-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ip4_csum.sv
// Combinational IPv4 header checksum over ten 16-bit words.
module ip4_csum
   import ip4_pkg::*;
(
   input  logic [IP4_HDR_BYTES/2-1:0][15:0] words,
   output logic [15:0]                      csum
);

   logic [19:0] acc;
   logic [16:0] fold1;
   logic [15:0] fold2;

   // Wide sum, two end-around carry folds, then invert.
   always_comb begin
      acc = '0;
      for (int i = 0; i < IP4_HDR_BYTES/2; i++) begin
         acc = acc + 20'(words[i]);
      end
      fold1 = 17'(acc[15:0]) + 17'(acc[19:16]);
      fold2 = fold1[15:0] + 16'(fold1[16]);
      csum  = ~fold2;
   end

endmodule

// File: rtl/ip4_header_insert.sv
// Prepends a 20-byte IPv4 header to an AXI-Stream payload packet.
//
// state | meaning
// IDLE  | wait for first payload beat; capture sideband and config
// CSUM  | register header checksum
// HDR0  | emit header bytes 0-7
// HDR0B | emit header bytes 8-15
// HDR1  | emit header bytes 16-19 plus payload bytes 0-3
// DATA  | emit held upper half of previous beat plus lower half of current
// TAIL  | flush held upper half after a last beat with more than 4 bytes
module ip4_header_insert
   import ip4_pkg::*;
#(
   parameter  int AXIS_BUS_WIDTH      = 64,
   parameter  int AXIS_ID_WIDTH       = 4,
   parameter  int AXIS_DEST_WIDTH     = 0,
   parameter  int MAX_PACKET_LENGTH   = 1522,
   localparam int ID_W                = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
   localparam int DEST_W              = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
   localparam int PACKET_LENGTH_CBITS = $clog2(MAX_PACKET_LENGTH + 1),
   localparam int USER_W              = PACKET_LENGTH_CBITS + 8,
   localparam int KEEP_W              = AXIS_BUS_WIDTH / 8,
   localparam int CFG_W               = SA_IP4_SIZE + DA_IP4_SIZE + 8
)(
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
   input  logic [KEEP_W-1:0]         axis_in_tkeep,
   input  logic                      axis_in_tlast,
   input  logic                      axis_in_tvalid,
   output logic                      axis_in_tready,
   input  logic [USER_W-1:0]         axis_in_tuser,
   input  logic [ID_W-1:0]           axis_in_tid,
   input  logic [DEST_W-1:0]         axis_in_tdest,
   output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
   output logic [KEEP_W-1:0]         axis_out_tkeep,
   output logic                      axis_out_tlast,
   output logic                      axis_out_tvalid,
   input  logic                      axis_out_tready,
   output logic [ID_W-1:0]           axis_out_tid,
   output logic [DEST_W-1:0]         axis_out_tdest,
   output logic [ID_W-1:0]           ip4_config_sel,
   input  logic [CFG_W-1:0]          ip4_config_regs
);

   ip4_state_e state_q, state_d;

   logic [USER_W-1:0] user_q;
   logic [ID_W-1:0]   tid_q;
   logic [DEST_W-1:0] tdest_q;
   logic [CFG_W-1:0]  cfg_q;
   logic [15:0]       csum_q;
   logic [15:0]       ident_q;
   logic [31:0]       hold_q;
   logic [3:0]        hold_keep_q;
   logic              hold_ld;

   logic [7:0]  proto;
   logic [7:0]  ttl;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] total_len;
   logic [15:0] csum_d;
   logic [IP4_HDR_BYTES/2-1:0][15:0] hdr_words;
   logic [63:0] beat0;
   logic [63:0] beat1;
   logic [31:0] dst_lanes;
   logic        in_short_last;

   assign proto     = user_q[USER_W-1 -: 8];
   assign total_len = 16'(user_q[PACKET_LENGTH_CBITS-1:0]) + 16'(IP4_HDR_BYTES);
   assign src_addr  = cfg_q[0 +: SA_IP4_SIZE];
   assign dst_addr  = cfg_q[SA_IP4_SIZE +: DA_IP4_SIZE];
   assign ttl       = cfg_q[SA_IP4_SIZE + DA_IP4_SIZE +: 8];

   // Word 0 in the low slot; the checksum word (5) is zero while summing.
   assign hdr_words = {dst_addr[15:0], dst_addr[31:16], src_addr[15:0], src_addr[31:16],
                       16'h0000, ttl, proto, IP4_FLAGS_FRAG, ident_q, total_len,
                       IP4_VER_IHL, 8'h00};

   ip4_csum u_csum (
      .words (hdr_words),
      .csum  (csum_d)
   );

   assign beat0     = be_to_lanes({IP4_VER_IHL, 8'h00, total_len, ident_q, IP4_FLAGS_FRAG});
   assign beat1     = be_to_lanes({ttl, proto, csum_q, src_addr});
   assign dst_lanes = {dst_addr[7:0], dst_addr[15:8], dst_addr[23:16], dst_addr[31:24]};

   // A last beat whose upper half is empty fits entirely in the current output beat.
   assign in_short_last = axis_in_tlast && (axis_in_tkeep[7:4] == 4'h0);

   assign axis_out_tid   = tid_q;
   assign axis_out_tdest = tdest_q;
   assign ip4_config_sel = (state_q == IDLE) ? axis_in_tid : tid_q;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Per-packet sideband, config and checksum capture.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         user_q  <= '0;
         tid_q   <= '0;
         tdest_q <= '0;
         cfg_q   <= '0;
         csum_q  <= '0;
      end else begin
         if (state_q == IDLE && axis_in_tvalid) begin
            user_q  <= axis_in_tuser;
            tid_q   <= axis_in_tid;
            tdest_q <= axis_in_tdest;
            cfg_q   <= ip4_config_regs;
         end
         if (state_q == CSUM) begin
            csum_q <= csum_d;
         end
      end
   end

   // Packet identifier and upper-half payload carry between beats.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ident_q     <= '0;
         hold_q      <= '0;
         hold_keep_q <= '0;
      end else begin
         if (state_q == HDR0 && axis_out_tready) begin
            ident_q <= ident_q + 16'd1;
         end
         if (hold_ld) begin
            hold_q      <= axis_in_tdata[63:32];
            hold_keep_q <= axis_in_tkeep[7:4];
         end
      end
   end

   // Next-state and stream outputs.
   always_comb begin
      state_d         = state_q;
      axis_in_tready  = 1'b0;
      axis_out_tvalid = 1'b0;
      axis_out_tdata  = '0;
      axis_out_tkeep  = '0;
      axis_out_tlast  = 1'b0;
      hold_ld         = 1'b0;
      case (state_q)
         IDLE: begin
            if (axis_in_tvalid) state_d = CSUM;
         end
         CSUM: begin
            state_d = HDR0;
         end
         HDR0: begin
            axis_out_tvalid = 1'b1;
            axis_out_tdata  = beat0;
            axis_out_tkeep  = 8'hFF;
            if (axis_out_tready) state_d = HDR0B;
         end
         HDR0B: begin
            axis_out_tvalid = 1'b1;
            axis_out_tdata  = beat1;
            axis_out_tkeep  = 8'hFF;
            if (axis_out_tready) state_d = HDR1;
         end
         HDR1, DATA: begin
            axis_out_tvalid = axis_in_tvalid;
            axis_in_tready  = axis_out_tready;
            axis_out_tlast  = in_short_last;
            if (state_q == HDR1) begin
               axis_out_tdata = {axis_in_tdata[31:0], dst_lanes};
               axis_out_tkeep = {axis_in_tkeep[3:0], 4'hF};
            end else begin
               axis_out_tdata = {axis_in_tdata[31:0], hold_q};
               axis_out_tkeep = {axis_in_tkeep[3:0], hold_keep_q};
            end
            if (axis_in_tvalid && axis_out_tready) begin
               hold_ld = 1'b1;
               if (!axis_in_tlast)    state_d = DATA;
               else if (in_short_last) state_d = IDLE;
               else                   state_d = TAIL;
            end
         end
         TAIL: begin
            axis_out_tvalid = 1'b1;
            axis_out_tdata  = {32'h0, hold_q};
            axis_out_tkeep  = {4'h0, hold_keep_q};
            axis_out_tlast  = 1'b1;
            if (axis_out_tready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ip4_header_insert.sv
// Scoreboard bench for ip4_header_insert: randomized packets, byte-level reference model.
module tb_ip4_header_insert;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [63:0] in_tdata;
   logic [7:0]  in_tkeep;
   logic        in_tlast;
   logic        in_tvalid;
   logic        in_tready;
   logic [18:0] in_tuser;
   logic [3:0]  in_tid;
   logic [0:0]  in_tdest;
   logic [63:0] out_tdata;
   logic [7:0]  out_tkeep;
   logic        out_tlast;
   logic        out_tvalid;
   logic        out_tready;
   logic [3:0]  out_tid;
   logic [0:0]  out_tdest;
   logic [3:0]  cfg_sel;
   logic [71:0] cfg_regs;
   logic [71:0] cfg_tab [16];

   assign cfg_regs = cfg_tab[cfg_sel];

   always #5 aclk = ~aclk;

   ip4_header_insert #(.AXIS_ID_WIDTH(4), .AXIS_DEST_WIDTH(0)) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .axis_in_tdata   (in_tdata),
      .axis_in_tkeep   (in_tkeep),
      .axis_in_tlast   (in_tlast),
      .axis_in_tvalid  (in_tvalid),
      .axis_in_tready  (in_tready),
      .axis_in_tuser   (in_tuser),
      .axis_in_tid     (in_tid),
      .axis_in_tdest   (in_tdest),
      .axis_out_tdata  (out_tdata),
      .axis_out_tkeep  (out_tkeep),
      .axis_out_tlast  (out_tlast),
      .axis_out_tvalid (out_tvalid),
      .axis_out_tready (out_tready),
      .axis_out_tid    (out_tid),
      .axis_out_tdest  (out_tdest),
      .ip4_config_sel  (cfg_sel),
      .ip4_config_regs (cfg_regs)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic [3:0]  tid;
      logic [0:0]  tdest;
   } beat_t;

   beat_t       exp_q [$];
   beat_t       seen_q [$];
   logic [7:0]  last_pl [$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] ident_m = 16'h0;
   bit          bp_on = 1'b0;
   int          pkt_beats = 0;
   int          last_pkt_beats = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] keep_mask(input logic [7:0] k);
      logic [63:0] m;
      for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{k[i]}};
      return m;
   endfunction

   // Reference: header as a byte list, RFC-style checksum, then header+payload chopped into 8-byte beats.
   task automatic push_expected(input int len, input logic [7:0] proto, input logic [3:0] tid,
                                input logic [0:0] tdest, input logic [7:0] pl [$]);
      logic [7:0]  b [$];
      logic [71:0] cfg;
      logic [15:0] tl;
      int unsigned s;
      beat_t       e;
      cfg = cfg_tab[tid];
      tl  = 16'(len + 20);
      b = {8'h45, 8'h00, tl[15:8], tl[7:0], ident_m[15:8], ident_m[7:0], 8'h40, 8'h00,
           cfg[71:64], proto, 8'h00, 8'h00,
           cfg[31:24], cfg[23:16], cfg[15:8], cfg[7:0],
           cfg[63:56], cfg[55:48], cfg[47:40], cfg[39:32]};
      s = 0;
      for (int i = 0; i < 20; i += 2) s += {16'h0, b[i], b[i+1]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      b[10] = ~s[15:8];
      b[11] = ~s[7:0];
      ident_m = ident_m + 16'd1;
      for (int i = 0; i < pl.size(); i++) b.push_back(pl[i]);
      for (int k = 0; k < b.size(); k += 8) begin
         e = '0;
         e.tid = tid;
         e.tdest = tdest;
         for (int j = 0; j < 8; j++) begin
            if (k + j < b.size()) begin
               e.data[8*j +: 8] = b[k+j];
               e.keep[j] = 1'b1;
            end
         end
         e.last = (k + 8 >= b.size());
         exp_q.push_back(e);
      end
   endtask

   // Drive one packet; abort_at >= 0 pulls reset while that input beat is presented.
   task automatic send_pkt(input int len, input logic [7:0] proto, input logic [3:0] tid,
                           input int abort_at, input bit chk_lat);
      logic [7:0] pl [$];
      logic [0:0] td;
      int         nb;
      bit         ok;
      td = 1'($urandom);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      last_pl = pl;
      push_expected(len, proto, tid, td, pl);
      nb = (len + 7) / 8;
      for (int bi = 0; bi < nb; bi++) begin
         for (int j = 0; j < 8; j++) begin
            in_tdata[8*j +: 8] = (bi*8 + j < len) ? pl[bi*8 + j] : 8'($urandom);
            in_tkeep[j]        = (bi*8 + j < len);
         end
         in_tlast = (bi == nb - 1);
         if (bi == 0) begin
            in_tuser = {proto, 11'(len)};
            in_tid   = tid;
            in_tdest = td;
         end else begin
            in_tuser = 19'($urandom);
            in_tid   = 4'($urandom);
            in_tdest = 1'($urandom);
         end
         in_tvalid = 1'b1;
         if (bi == 0 && chk_lat) begin
            @(negedge aclk); chk("lat_idle", out_tvalid, 0);
            @(negedge aclk); chk("lat_csum", out_tvalid, 0);
            @(negedge aclk); chk("lat_hdr0", out_tvalid, 1);
            @(posedge aclk); #1;
         end
         if (bi == abort_at) begin
            #2;
            chk("pre_rst_valid", out_tvalid, 1);
            aresetn = 1'b0;
            #1;
            chk("rst_async_valid", out_tvalid, 0);
            chk("rst_async_ready", in_tready, 0);
            in_tvalid = 1'b0;
            in_tlast  = 1'b0;
            exp_q.delete();
            ident_m   = 16'h0;
            pkt_beats = 0;
            repeat (2) @(posedge aclk);
            @(negedge aclk);
            aresetn = 1'b1;
            @(posedge aclk); #1;
            return;
         end
         ok = 1'b0;
         for (int cyc = 0; cyc < 500 && !ok; cyc++) begin
            @(negedge aclk);
            if (in_tready) ok = 1'b1;
            @(posedge aclk); #1;
         end
         if (!ok) begin
            total++;
            bad++;
            $display("FAIL in_handshake_timeout: tready 0 for 500 cycles, expected 1");
            in_tvalid = 1'b0;
            return;
         end
      end
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge aclk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
      end
      @(posedge aclk); #1;
   endtask

   // Output ready: always 1, or a fair coin per cycle while backpressure is on.
   initial begin
      out_tready = 1'b1;
      forever begin
         @(posedge aclk); #1;
         out_tready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pop and compare on every output handshake; check stability while stalled.
   initial begin : monitor
      beat_t cur;
      beat_t prev;
      beat_t e;
      bit    stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge aclk);
         if (!aresetn) begin
            stall = 1'b0;
         end else begin
            cur.data  = out_tdata;
            cur.keep  = out_tkeep;
            cur.last  = out_tlast;
            cur.tid   = out_tid;
            cur.tdest = out_tdest;
            if (stall) begin
               chk("stall_valid", out_tvalid, 1);
               chk("stall_data", cur.data, prev.data);
               chk("stall_keep", cur.keep, prev.keep);
               chk("stall_last", cur.last, prev.last);
            end
            if (out_tvalid && out_tready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_beat: got data %h, expected no beat", out_tdata);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_keep", cur.keep, e.keep);
                  chk("beat_data", cur.data & keep_mask(e.keep), e.data);
                  chk("beat_last", cur.last, e.last);
                  chk("beat_tid", cur.tid, e.tid);
                  chk("beat_tdest", cur.tdest, e.tdest);
               end
               seen_q.push_back(cur);
               pkt_beats++;
               if (out_tlast) begin
                  last_pkt_beats = pkt_beats;
                  pkt_beats = 0;
               end
            end
            stall = out_tvalid && !out_tready;
            prev  = cur;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      beat_t b;
      for (int i = 0; i < 16; i++) cfg_tab[i] = {8'($urandom), 32'($urandom), 32'($urandom)};
      in_tdata  = '0;
      in_tkeep  = '0;
      in_tlast  = 1'b0;
      in_tvalid = 1'b0;
      in_tuser  = '0;
      in_tid    = '0;
      in_tdest  = '0;
      aresetn   = 1'b0;

      repeat (3) @(posedge aclk); #1;
      chk("rst_out_valid", out_tvalid, 0);
      chk("rst_in_ready", in_tready, 0);
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("idle_out_valid", out_tvalid, 0);

      // Golden header, first packet after reset.
      cfg_tab[3] = {8'h40, 32'hC0A800C7, 32'hC0A80001};
      seen_q.delete();
      send_pkt(95, 8'h11, 4'h3, -1, 1'b1);
      wait_drain();
      b = seen_q[0];
      chk("gold_beat0", b.data, 64'h0040000073000045);
      chk("gold_keep0", b.keep, 8'hFF);
      b = seen_q[1];
      chk("gold_beat1", b.data, 64'h0100A8C061B81140);

      // Single short beat.
      seen_q.delete();
      send_pkt(4, 8'($urandom), 4'($urandom), -1, 1'b0);
      wait_drain();
      chk("short_beats", last_pkt_beats, 3);
      b = seen_q[2];
      chk("short_last_keep", b.keep, 8'hFF);
      chk("short_last_flag", b.last, 1);

      // 16-byte payload ending in a tail beat.
      seen_q.delete();
      send_pkt(16, 8'($urandom), 4'($urandom), -1, 1'b0);
      wait_drain();
      chk("tail_beats", last_pkt_beats, 5);
      b = seen_q[4];
      chk("tail_keep", b.keep, 8'h0F);
      chk("tail_bytes", b.data[31:0], {last_pl[15], last_pl[14], last_pl[13], last_pl[12]});

      // Random lengths under random backpressure.
      bp_on = 1'b1;
      for (int p = 0; p < 100; p++) begin
         send_pkt($urandom_range(1, 120), 8'($urandom), 4'($urandom), -1, 1'b0);
      end
      wait_drain();

      // ident wrap from 0xFFFF.
      @(negedge aclk);
      force dut.ident_q = 16'hFFFF;
      ident_m = 16'hFFFF;
      @(negedge aclk);
      release dut.ident_q;
      @(posedge aclk); #1;
      seen_q.delete();
      send_pkt(4, 8'($urandom), 4'($urandom), -1, 1'b0);
      send_pkt(4, 8'($urandom), 4'($urandom), -1, 1'b0);
      wait_drain();
      b = seen_q[0];
      chk("wrap_ident_ffff", {b.data[39:32], b.data[47:40]}, 16'hFFFF);
      b = seen_q[3];
      chk("wrap_ident_0000", {b.data[39:32], b.data[47:40]}, 16'h0000);
      bp_on = 1'b0;
      wait_drain();

      // Reset while in DATA, then a clean packet.
      send_pkt(40, 8'($urandom), 4'($urandom), 2, 1'b0);
      chk("post_rst_valid", out_tvalid, 0);
      seen_q.delete();
      send_pkt(8, 8'($urandom), 4'($urandom), -1, 1'b0);
      wait_drain();
      b = seen_q[0];
      chk("post_rst_ident", {b.data[39:32], b.data[47:40]}, 16'h0000);
      chk("post_rst_beats", last_pkt_beats, 4);

      repeat (5) @(posedge aclk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
